// File: rtl/param_stack.sv
// LIFO stack over a DEPTH-entry circular buffer with PUSH/POP/GET-by-index.
// Outputs are registered; a full-stack push either drops the oldest entry or raises ERROR.
module param_stack #(
   parameter  int WIDTH     = 4,
   parameter  int DEPTH     = 5,
   parameter  int OVERWRITE = 1,
   localparam int IW        = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       command_i,
   input  logic [IW-1:0]    index_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             error_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;
   localparam logic [1:0] CMD_GET  = 2'b11;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [IW-1:0]    head_q, head_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             wr_en;

   logic [IW-1:0]    head_inc, head_dec, get_slot;
   logic [IW:0]      top_x, idx_x, slot_x;
   logic             index_ok;

   // Explicit modulo-DEPTH wrap; DEPTH need not be a power of two.
   assign head_inc = (head_q == IW'(DEPTH - 1)) ? '0 : head_q + IW'(1);
   assign head_dec = (head_q == '0) ? IW'(DEPTH - 1) : head_q - IW'(1);

   // Slot (HEAD-1-k) mod DEPTH, computed one bit wider to avoid binary wrap.
   assign top_x    = {1'b0, head_dec};
   assign idx_x    = {1'b0, index_i};
   assign slot_x   = (idx_x <= top_x) ? (top_x - idx_x)
                                      : (top_x + (IW+1)'(DEPTH) - idx_x);
   assign get_slot = slot_x[IW-1:0];
   assign index_ok = (CW'(index_i) < count_q);

   always_comb begin
      head_d  = head_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      wr_en   = 1'b0;
      case (command_i)
         CMD_PUSH: begin
            if (!full_q || (OVERWRITE != 0)) begin
               wr_en  = 1'b1;
               head_d = head_inc;
               if (!full_q) begin
                  count_d = count_q + CW'(1);
               end
            end else begin
               error_d = 1'b1;
            end
         end
         CMD_POP: begin
            if (!empty_q) begin
               data_d  = mem_q[head_dec];
               head_d  = head_dec;
               count_d = count_q - CW'(1);
               valid_d = 1'b1;
            end else begin
               error_d = 1'b1;
            end
         end
         CMD_GET: begin
            if (index_ok) begin
               data_d  = mem_q[get_slot];
               valid_d = 1'b1;
            end else begin
               error_d = 1'b1;
            end
         end
         CMD_NOP: ;
         default: ;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Storage holds no reset: slots beyond COUNT are never observable.
   always_ff @(posedge clk) begin
      if (wr_en && rst_n) begin
         mem_q[head_q] <= data_i;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign error_o = error_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: overwrite and reject policies at depth 5, wrap at depth 8.
module tb_param_stack;

   localparam logic [1:0] NOP  = 2'b00;
   localparam logic [1:0] PUSH = 2'b01;
   localparam logic [1:0] POP  = 2'b10;
   localparam logic [1:0] GET  = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cmd [3];
   logic [2:0] idx [3];
   logic [7:0] din [3];

   logic [3:0] dout0, dout1;
   logic [7:0] dout2;
   logic       vld0, vld1, vld2, err0, err1, err2;
   logic       ful0, ful1, ful2, emp0, emp1, emp2;
   logic [2:0] cnt0, cnt1;
   logic [3:0] cnt2;

   logic [7:0] o_data;
   logic       o_valid, o_err, o_full, o_empty;
   logic [3:0] o_count;

   int n_err = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   param_stack #(.WIDTH(4), .DEPTH(5), .OVERWRITE(1)) u_ow (
      .clk(clk), .rst_n(rst_n), .command_i(cmd[0]), .index_i(idx[0]), .data_i(din[0][3:0]),
      .data_o(dout0), .valid_o(vld0), .error_o(err0), .full_o(ful0), .empty_o(emp0), .count_o(cnt0));

   param_stack #(.WIDTH(4), .DEPTH(5), .OVERWRITE(0)) u_rej (
      .clk(clk), .rst_n(rst_n), .command_i(cmd[1]), .index_i(idx[1]), .data_i(din[1][3:0]),
      .data_o(dout1), .valid_o(vld1), .error_o(err1), .full_o(ful1), .empty_o(emp1), .count_o(cnt1));

   param_stack #(.WIDTH(8), .DEPTH(8), .OVERWRITE(0)) u_d8 (
      .clk(clk), .rst_n(rst_n), .command_i(cmd[2]), .index_i(idx[2]), .data_i(din[2]),
      .data_o(dout2), .valid_o(vld2), .error_o(err2), .full_o(ful2), .empty_o(emp2), .count_o(cnt2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic sample(input int u);
      case (u)
         0: begin
            o_data = {4'b0, dout0}; o_valid = vld0; o_err = err0;
            o_full = ful0; o_empty = emp0; o_count = {1'b0, cnt0};
         end
         1: begin
            o_data = {4'b0, dout1}; o_valid = vld1; o_err = err1;
            o_full = ful1; o_empty = emp1; o_count = {1'b0, cnt1};
         end
         default: begin
            o_data = dout2; o_valid = vld2; o_err = err2;
            o_full = ful2; o_empty = emp2; o_count = cnt2;
         end
      endcase
   endtask

   task automatic step(input int u, input logic [1:0] c, input logic [2:0] i, input logic [7:0] d);
      cmd[u] = c;
      idx[u] = i;
      din[u] = d;
      @(posedge clk);
      #1;
      cmd[u] = NOP;
      sample(u);
      $display("t=%0t u%0d cmd=%0d idx=%0d din=%0h -> data=%0h valid=%b err=%b full=%b empty=%b count=%0d",
               $time, u, c, i, d, o_data, o_valid, o_err, o_full, o_empty, o_count);
   endtask

   task automatic push(input int u, input logic [7:0] d);
      step(u, PUSH, 3'd0, d);
   endtask

   task automatic read_ok(input int u, input logic [1:0] c, input logic [2:0] i,
                          input logic [7:0] exp, input string tag);
      step(u, c, i, 8'h00);
      check({tag, " data"}, o_data, exp);
      check({tag, " valid"}, o_valid, 1);
      check({tag, " error"}, o_err, 0);
   endtask

   task automatic read_err(input int u, input logic [1:0] c, input logic [2:0] i,
                           input logic [7:0] hold, input string tag);
      step(u, c, i, 8'h00);
      check({tag, " error"}, o_err, 1);
      check({tag, " valid"}, o_valid, 0);
      check({tag, " data hold"}, o_data, hold);
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         cmd[u] = NOP;
         idx[u] = '0;
         din[u] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         sample(u);
         check("reset data", o_data, 0);
         check("reset valid", o_valid, 0);
         check("reset error", o_err, 0);
         check("reset full", o_full, 0);
         check("reset empty", o_empty, 1);
         check("reset count", o_count, 0);
      end
      rst_n = 1'b1;

      // Basic LIFO order and one-cycle valid pulse
      push(0, 8'd1); push(0, 8'd2); push(0, 8'd3);
      read_ok(0, POP, 3'd0, 8'd3, "t1 pop3");
      check("t1 count", o_count, 2);
      check("t1 empty", o_empty, 0);
      step(0, NOP, 3'd0, 8'd0);
      check("t1 valid pulse", o_valid, 0);
      check("t1 nop data", o_data, 3);
      read_ok(0, POP, 3'd0, 8'd2, "t1 pop2");
      read_ok(0, POP, 3'd0, 8'd1, "t1 pop1");
      check("t1 empty after", o_empty, 1);

      // Empty-stack errors
      read_err(1, POP, 3'd0, 8'd0, "t3 pop empty");
      check("t3 count", o_count, 0);
      read_err(1, GET, 3'd0, 8'd0, "t3 get empty");

      // GET by index
      push(1, 8'd10); push(1, 8'd11); push(1, 8'd12);
      read_ok(1, GET, 3'd0, 8'd12, "t2 get0");
      read_ok(1, GET, 3'd2, 8'd10, "t2 get2");
      check("t2 count", o_count, 3);
      read_err(1, GET, 3'd3, 8'd10, "t2 get3");
      step(1, NOP, 3'd0, 8'd0);
      check("t2 error pulse", o_err, 0);
      read_ok(1, POP, 3'd0, 8'd12, "t2 drain12");
      read_ok(1, POP, 3'd0, 8'd11, "t2 drain11");
      read_ok(1, POP, 3'd0, 8'd10, "t2 drain10");

      // Full push rejected
      for (int k = 1; k <= 5; k++) push(1, 8'(k));
      check("t5 full", o_full, 1);
      check("t5 count5", o_count, 5);
      push(1, 8'd6);
      check("t5 push6 error", o_err, 1);
      check("t5 push6 count", o_count, 5);
      read_ok(1, GET, 3'd4, 8'd1, "t5 get4");
      read_ok(1, POP, 3'd0, 8'd5, "t5 pop");
      check("t5 count4", o_count, 4);
      check("t5 not full", o_full, 0);
      read_err(1, GET, 3'd5, 8'd5, "t5 get idx>=depth");
      read_ok(1, GET, 3'd3, 8'd1, "t5 get3");

      // Full push overwrites oldest
      for (int k = 1; k <= 5; k++) push(0, 8'(k));
      check("t4 full", o_full, 1);
      push(0, 8'd6);
      check("t4 push6 error", o_err, 0);
      check("t4 push6 count", o_count, 5);
      check("t4 push6 full", o_full, 1);
      read_ok(0, GET, 3'd4, 8'd2, "t4 get4");
      for (int k = 6; k >= 2; k--) read_ok(0, POP, 3'd0, 8'(k), "t4 pop");
      check("t4 empty", o_empty, 1);
      read_err(0, POP, 3'd0, 8'd2, "t4 pop empty");

      // Depth 8 wrap
      for (int k = 1; k <= 8; k++) push(2, 8'hA0 + 8'(k));
      check("t5b full", o_full, 1);
      check("t5b count8", o_count, 8);
      for (int k = 8; k >= 6; k--) read_ok(2, POP, 3'd0, 8'hA0 + 8'(k), "t5b pop a");
      for (int k = 1; k <= 3; k++) push(2, 8'hB0 + 8'(k));
      check("t5b count after refill", o_count, 8);
      read_ok(2, GET, 3'd7, 8'hA1, "t5b get7");
      for (int k = 3; k >= 1; k--) read_ok(2, POP, 3'd0, 8'hB0 + 8'(k), "t5b pop b");
      for (int k = 5; k >= 1; k--) read_ok(2, POP, 3'd0, 8'hA0 + 8'(k), "t5b pop a");
      check("t5b empty", o_empty, 1);

      // Asynchronous mid-cycle reset
      push(0, 8'd7); push(0, 8'd9);
      read_ok(0, GET, 3'd0, 8'd9, "t6 get0");
      #2;
      rst_n = 1'b0;
      #1;
      sample(0);
      check("t6 async data", o_data, 0);
      check("t6 async valid", o_valid, 0);
      check("t6 async count", o_count, 0);
      check("t6 async empty", o_empty, 1);
      check("t6 async full", o_full, 0);
      cmd[0] = PUSH;
      din[0] = 8'd5;
      @(posedge clk);
      #1;
      cmd[0] = NOP;
      sample(0);
      check("t6 cmd ignored in reset", o_count, 0);
      rst_n = 1'b1;
      push(0, 8'd4);
      check("t6 count1", o_count, 1);
      read_ok(0, POP, 3'd0, 8'd4, "t6 pop4");
      check("t6 count0", o_count, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "timeout");
   end

endmodule
